dct_da_sequencer: RTL

Cycle-level controller for the bit-serial distributed-arithmetic DCT coefficient datapaths (one per coefficient row). It accepts 8-sample blocks from upstream, sequences the parallel load, the N_BITS-cycle LSB-first shift/ROM/accumulate pass, and the result capture. It then presents each captured coefficient set to the downstream run-length encoder over a valid/ready handshake. It replaces the separate divided output clock with a single-cycle capture strobe, so the whole DCT stage runs on one clock.

---
 rtl/dct_da_sequencer_if.sv | 34 +++
 rtl/dct_da_sequencer.sv | 92 +++++++++
 2 files changed

// File: rtl/dct_da_sequencer_if.sv
// Control/handshake bundle between the DA DCT sequencer and its datapath,
// upstream block source and downstream run-length encoder.
interface dct_da_sequencer_if #(
  parameter int N_BITS = 8,
  parameter int CNT_W  = 8
);
  localparam int BW = $clog2(N_BITS);

  logic          in_valid;
  logic          in_ready;
  logic          ld;
  logic          en;
  logic          cs;
  logic          acc_clr;
  logic          sign_bit;
  logic [BW-1:0] bit_idx;
  logic          capture;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic [CNT_W-1:0] blk_cnt;

  modport master (
    input  in_valid, out_ready,
    output in_ready, ld, en, cs, acc_clr, sign_bit, bit_idx,
           capture, out_valid, busy, blk_cnt
  );

  modport slave (
    output in_valid, out_ready,
    input  in_ready, ld, en, cs, acc_clr, sign_bit, bit_idx,
           capture, out_valid, busy, blk_cnt
  );
endinterface

// File: rtl/dct_da_sequencer.sv
// Sequences load / N_BITS-cycle LSB-first DA pass / capture for the DCT rows,
// then hands each coefficient set downstream; capture stalls while a result is unconsumed.
module dct_da_sequencer #(
  parameter int N_BITS = 8,
  parameter int CNT_W  = 8
) (
  input  logic clk,
  input  logic reset,
  dct_da_sequencer_if.master bus
);
  localparam int BW = $clog2(N_BITS);
  localparam logic [BW-1:0] LAST = BW'(N_BITS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, CAPT} state_t;

  state_t           state, state_nxt;
  logic [BW-1:0]    bit_idx;
  logic             out_valid;
  logic [CNT_W-1:0] blk_cnt;
  logic             fire, hs;
  logic             in_ready, capture, ld, en, cs, acc_clr, sign_bit;

  // Capture may only overwrite the output registers once they are free or being drained.
  assign fire = !out_valid || bus.out_ready;
  assign hs   = out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_idx   <= '0;
      out_valid <= 1'b0;
      blk_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      bit_idx   <= (state == SHIFT && bit_idx != LAST) ? bit_idx + 1'b1 : '0;
      out_valid <= capture || (out_valid && !hs);
      if (hs)
        blk_cnt <= blk_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    capture   = 1'b0;
    ld        = 1'b0;
    en        = 1'b0;
    cs        = 1'b0;
    acc_clr   = 1'b0;
    sign_bit  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid)
          state_nxt = LOAD;
      end
      LOAD: begin
        ld        = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        en       = 1'b1;
        cs       = 1'b1;
        acc_clr  = (bit_idx == '0);
        sign_bit = (bit_idx == LAST);
        if (bit_idx == LAST)
          state_nxt = CAPT;
      end
      CAPT: begin
        // Accepting here keeps back-to-back blocks free of an IDLE bubble.
        if (fire) begin
          capture   = 1'b1;
          in_ready  = 1'b1;
          state_nxt = bus.in_valid ? LOAD : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.capture   = capture;
  assign bus.ld        = ld;
  assign bus.en        = en;
  assign bus.cs        = cs;
  assign bus.acc_clr   = acc_clr;
  assign bus.sign_bit  = sign_bit;
  assign bus.bit_idx   = bit_idx;
  assign bus.out_valid = out_valid;
  assign bus.busy      = (state != IDLE);
  assign bus.blk_cnt   = blk_cnt;
endmodule
